load_sequencer: RTL and testbench
=================================

Name: load_sequencer

Overview:
- Upstream feeder for the key/message deserializers of the XOR encryption core.
- Accepts one 8-bit key and one 64-bit message in parallel through a valid/ready handshake.
- Drives them onto the shared serial line, MSB first:
  - key frame with the load-key strobe high;
  - idle gap;
  - message frame with the load-message strobe high;
  - one-cycle done pulse.
- Outputs connect directly to the core's serial-in, load-key and load-message inputs.

Parameters:
- KEY_SIZE, 8, key width in bits; equals the key deserializer's DATA_SIZE.
- MSG_SIZE, 64, message width in bits; equals the message deserializer's DATA_SIZE.
- GAP_CYCLES, 1, idle cycles between key and message frames; 0 means the GAP state is skipped.

Ports:
- iClk  in  1  single clock; all state updates on rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iEn  in  1  enable; low freezes all state.
- iKey  in  KEY_SIZE  parallel key; sampled on handshake.
- iMessage  in  MSG_SIZE  parallel message; sampled on handshake.
- iValid  in  1  producer has key+message available.
- oReady  out  1  sequencer can accept; equals (state==IDLE) & iEn.
- oSerial_out  out  1  serial data to the deserializers.
- oLoad_key  out  1  high exactly during the KEY_SIZE key bit cycles.
- oLoad_msg  out  1  high exactly during the MSG_SIZE message bit cycles.
- oBusy  out  1  high in every state other than IDLE.
- oDone  out  1  one-cycle pulse after the last message bit.

Behaviour:
- Reset (async, iRst=1):
  - state=IDLE, bit counter=0, shadow key/message registers=0.
  - All outputs 0 except oReady, which follows iEn.
  - Reset mid-frame aborts immediately; no partial frame resumes.
- States: IDLE, KEY, GAP, MSG, DONE. Moore outputs decoded from the registered state, counter and shadow registers.
- IDLE:
  - Handshake = iValid & oReady at a rising edge.
  - On handshake: capture iKey/iMessage into shadow regs, clear counter, go to KEY.
  - iValid without handshake: no effect.
- KEY:
  - oLoad_key=1; oSerial_out=key_shadow[KEY_SIZE-1-cnt].
  - cnt increments each enabled cycle.
  - At cnt==KEY_SIZE-1: clear cnt; go to GAP, or to MSG if GAP_CYCLES==0.
- GAP:
  - Both load flags 0; oSerial_out=0.
  - Lasts GAP_CYCLES cycles, then clear cnt and go to MSG.
- MSG:
  - oLoad_msg=1; oSerial_out=msg_shadow[MSG_SIZE-1-cnt].
  - At cnt==MSG_SIZE-1: go to DONE.
- DONE:
  - oDone=1 for one cycle, then go to IDLE.
  - oReady is high again in the cycle after DONE.
- Latency, GAP_CYCLES=1, handshake at edge 0:
  - key bits occupy cycles 1..8;
  - gap cycle 9;
  - message bits occupy cycles 10..73;
  - oDone in cycle 74;
  - oReady in cycle 75.
- In general, total busy cycles = KEY_SIZE + GAP_CYCLES + MSG_SIZE + 1.
- iEn=0:
  - State, counter and shadows hold; outputs hold their current values.
  - oReady=0.
  - The core's deserializers share the same enable, so a held flag does not shift extra bits.
- While busy:
  - iValid and iKey/iMessage are ignored; shadows are never overwritten mid-sequence.
- Never allowed:
  - oLoad_key and oLoad_msg high in the same cycle.
  - Any load flag high in IDLE, GAP or DONE.
- Counter width is $clog2(MSG_SIZE+1). It never exceeds MSG_SIZE-1 and wraps only through explicit clear.

Decomposition:
- Shared package:
  - state enum (IDLE, KEY, GAP, MSG, DONE);
  - default size constants KEY_SIZE_D=8, MSG_SIZE_D=64;
  - counter-width function.
  The deserializer and serializer reuse the same size constants.
- One sub-module, piso_shifter (parameter WIDTH): load, shift-enable and MSB output.
  - Instantiated twice: key and message.
  - The top holds the FSM and counter.

Test Plan:
- Basic frame:
  - Stimulus: reset, then iKey=0xA5, iMessage=0x0123456789ABCDEF, iValid=1 for one cycle.
  - Required: oSerial_out bits 1,0,1,0,0,1,0,1 with oLoad_key=1 for exactly 8 cycles; one gap cycle with both flags 0; 64 message bits starting 0,0,0,0,0,0,0,1 with oLoad_msg=1 for exactly 64 cycles; oDone in cycle 74.
- End-to-end:
  - Stimulus: drive the encryption core from this block with key 0xFF and message 0x00000000000000FF.
  - Required: core ciphertext = 0xFFFFFFFFFFFFFF00.
- Enable stall:
  - Stimulus: drop iEn for 5 cycles after the 3rd key bit.
  - Required: outputs frozen for those 5 cycles; stream resumes at bit 4; total busy = 79 cycles.
- Reset mid-message:
  - Stimulus: assert iRst at message bit 20.
  - Required: all outputs 0 asynchronously; state IDLE; next handshake produces a clean full frame.
- Busy ignore:
  - Stimulus: new iValid with key 0x3C while in MSG.
  - Required: oReady=0, shadows unchanged, stream unaffected; 0x3C is accepted only after DONE.
- GAP_CYCLES=0 instance:
  - Required: message bit 0 immediately follows key bit 7; oDone in cycle 73.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// Shared types and size constants for the key/message load path.
// Latency: n/a (package only).
// Backpressure: n/a.
package load_sequencer_pkg;

  // Sequencer states; DONE is the one-cycle completion pulse state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_GAP  = 3'd2,
    ST_MSG  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Default frame sizes, matching the deserializers' DATA_SIZE.
  localparam int KEY_SIZE_D = 8;
  localparam int MSG_SIZE_D = 64;

  // Bit-counter width able to index every message bit (and hold MSG_SIZE).
  function automatic int cnt_width(input int msg_size);
    if (msg_size + 1 <= 2) begin
      return 1;
    end
    return $clog2(msg_size + 1);
  endfunction

endpackage

// File: rtl/load_sequencer_piso.sv
// Parallel-in serial-out shift register presenting its MSB as the serial bit.
// Latency: load visible on msb_o the cycle after the loading edge.
// Backpressure: en_i low freezes the register contents.
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load has priority over shift; shifting moves the next bit into the MSB.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shadow register, cleared by reset and held while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else if (en_i) begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/load_sequencer.sv
// Serialises one key then one message (MSB first) onto the shared serial line.
// Latency: KEY_SIZE + GAP_CYCLES + MSG_SIZE + 1 busy cycles per handshake.
// Backpressure: oReady only in IDLE with iEn; iEn low freezes everything.
module load_sequencer
  import load_sequencer_pkg::*;
#(
  parameter int KEY_SIZE   = KEY_SIZE_D,
  parameter int MSG_SIZE   = MSG_SIZE_D,
  parameter int GAP_CYCLES = 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic [MSG_SIZE-1:0] iMessage,
  input  logic                iValid,
  output logic                oReady,
  output logic                oSerial_out,
  output logic                oLoad_key,
  output logic                oLoad_msg,
  output logic                oBusy,
  output logic                oDone
);

  localparam int CW = cnt_width(MSG_SIZE);
  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_SIZE - 1);
  localparam logic [CW-1:0] MSG_LAST = CW'(MSG_SIZE - 1);
  // With no gap the GAP state is unreachable, so its terminal count is moot.
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          key_bit;
  logic          msg_bit;

  // Shadows are loaded only on an accepted handshake, never mid-sequence.
  assign accept = (state_q == ST_IDLE) & iValid;

  piso_shifter #(.WIDTH(KEY_SIZE)) u_key_shift (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .en_i    (iEn),
    .load_i  (accept),
    .shift_i (state_q == ST_KEY),
    .data_i  (iKey),
    .msb_o   (key_bit)
  );

  piso_shifter #(.WIDTH(MSG_SIZE)) u_msg_shift (
    .clk_i   (iClk),
    .rst_i   (iRst),
    .en_i    (iEn),
    .load_i  (accept),
    .shift_i (state_q == ST_MSG),
    .data_i  (iMessage),
    .msb_o   (msg_bit)
  );

  // Frame sequencing: state and bit counter advance only on enabled cycles.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (iEn) begin
      case (state_q)
        ST_IDLE: begin
          if (iValid) begin
            cnt_q   <= '0;
            state_q <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (cnt_q == KEY_LAST) begin
            cnt_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? ST_MSG : ST_GAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_MSG;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_MSG: begin
          if (cnt_q == MSG_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore decode from registered state, so a frozen state freezes the outputs.
  always_comb begin
    oSerial_out = 1'b0;
    oLoad_key   = 1'b0;
    oLoad_msg   = 1'b0;
    oBusy       = (state_q != ST_IDLE);
    oDone       = 1'b0;
    case (state_q)
      ST_KEY: begin
        oLoad_key   = 1'b1;
        oSerial_out = key_bit;
      end
      ST_MSG: begin
        oLoad_msg   = 1'b1;
        oSerial_out = msg_bit;
      end
      ST_DONE: oDone = 1'b1;
      default: ;
    endcase
  end

  assign oReady = (state_q == ST_IDLE) & iEn;

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  key;
  logic [63:0] msg;
  logic        valid0, valid1;
  logic        ready0, ser0, lk0, lm0, busy0, done0;
  logic        ready1, ser1, lk1, lm1, busy1, done1;
  logic        sel;
  logic        s_ready, s_ser, s_lk, s_lm, s_busy, s_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  cap_kb;
  logic [63:0] cap_mb;
  int cap_keycnt, cap_msgcnt, cap_gapcnt, cap_busycnt, cap_done, cap_viol;

  always #5 clk = ~clk;

  load_sequencer #(.KEY_SIZE(8), .MSG_SIZE(64), .GAP_CYCLES(1)) dut_gap1 (
    .iClk(clk), .iRst(rst), .iEn(en), .iKey(key), .iMessage(msg), .iValid(valid0),
    .oReady(ready0), .oSerial_out(ser0), .oLoad_key(lk0), .oLoad_msg(lm0),
    .oBusy(busy0), .oDone(done0)
  );

  load_sequencer #(.KEY_SIZE(8), .MSG_SIZE(64), .GAP_CYCLES(0)) dut_gap0 (
    .iClk(clk), .iRst(rst), .iEn(en), .iKey(key), .iMessage(msg), .iValid(valid1),
    .oReady(ready1), .oSerial_out(ser1), .oLoad_key(lk1), .oLoad_msg(lm1),
    .oBusy(busy1), .oDone(done1)
  );

  assign s_ready = sel ? ready1 : ready0;
  assign s_ser   = sel ? ser1   : ser0;
  assign s_lk    = sel ? lk1    : lk0;
  assign s_lm    = sel ? lm1    : lm0;
  assign s_busy  = sel ? busy1  : busy0;
  assign s_done  = sel ? done1  : done0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one key/message pair to the selected instance; returns just after the accepting edge.
  task automatic handshake(input logic s, input logic [7:0] k, input logic [63:0] m);
    @(negedge clk);
    sel = s;
    key = k;
    msg = m;
    en  = 1'b1;
    if (s) valid1 = 1'b1;
    else   valid0 = 1'b1;
    #1;
    check("ready_before_handshake", 64'(s_ready), 64'(1));
    @(posedge clk);
  endtask

  // Observe one frame cycle by cycle, acting as the deserializers would (bits shift only when enabled).
  task automatic capture(input int stall_start, input int stall_len, input int inject_at,
                         input logic [7:0] inj_key);
    logic [4:0] snap;
    bit finished;
    bit stalled;
    cap_kb = '0; cap_mb = '0;
    cap_keycnt = 0; cap_msgcnt = 0; cap_gapcnt = 0; cap_busycnt = 0; cap_viol = 0;
    cap_done = -1;
    finished = 1'b0;
    snap = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        valid0 = 1'b0;
        valid1 = 1'b0;
      end
      stalled = (stall_len > 0) && (c >= stall_start) && (c < stall_start + stall_len);
      en = !stalled;
      if (c == inject_at) begin
        key    = inj_key;
        msg    = 64'h1111_2222_3333_4444;
        valid0 = 1'b1;
      end
      #1;
      if (s_busy) cap_busycnt++;
      if (en) begin
        if (s_lk) begin cap_kb = {cap_kb[6:0], s_ser}; cap_keycnt++; end
        if (s_lm) begin cap_mb = {cap_mb[62:0], s_ser}; cap_msgcnt++; end
        if (s_busy && !s_lk && !s_lm && !s_done) cap_gapcnt++;
      end
      if (s_lk && s_lm) cap_viol++;
      if ((s_lk || s_lm) && (!s_busy || s_done)) cap_viol++;
      if (stalled) begin
        check("stall_ready_low", 64'(s_ready), 64'(0));
        if (c == stall_start) snap = {s_ser, s_lk, s_lm, s_busy, s_done};
        else check("stall_outputs_frozen", 64'({s_ser, s_lk, s_lm, s_busy, s_done}), 64'(snap));
      end
      if (c == inject_at) check("busy_ignore_ready_low", 64'(s_ready), 64'(0));
      if (s_done && cap_done < 0) cap_done = c;
      if (cap_done > 0 && c == cap_done + 1) begin
        check("ready_after_done", 64'(s_ready), 64'(1));
        check("idle_after_done", 64'(s_busy), 64'(0));
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: got no done within 200 cycles, required done pulse");
    end
  endtask

  task automatic check_frame(input logic [7:0] ek, input logic [63:0] em, input int edone,
                             input int ebusy, input int egap);
    check("key_bits", 64'(cap_kb), 64'(ek));
    check("msg_bits", cap_mb, em);
    check("key_flag_cycles", 64'(cap_keycnt), 64'(8));
    check("msg_flag_cycles", 64'(cap_msgcnt), 64'(64));
    check("done_cycle", 64'(cap_done), 64'(edone));
    check("busy_cycles", 64'(cap_busycnt), 64'(ebusy));
    check("gap_cycles", 64'(cap_gapcnt), 64'(egap));
    check("flag_violations", 64'(cap_viol), 64'(0));
  endtask

  typedef struct {
    logic        sel;
    logic [7:0]  key;
    logic [63:0] msg;
    logic [7:0]  exp_kb;
    logic [63:0] exp_mb;
    int          exp_done;
    int          exp_gap;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 64'h0123_4567_89AB_CDEF, 8'hA5, 64'h0123_4567_89AB_CDEF, 74, 1};
    vecs[1] = '{1'b0, 8'hFF, 64'h0000_0000_0000_00FF, 8'hFF, 64'h0000_0000_0000_00FF, 74, 1};
    vecs[2] = '{1'b0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 74, 1};
    vecs[3] = '{1'b1, 8'h81, 64'h8000_0000_0000_0001, 8'h81, 64'h8000_0000_0000_0001, 73, 0};
    vecs[4] = '{1'b1, 8'h5A, 64'hDEAD_BEEF_CAFE_F00D, 8'h5A, 64'hDEAD_BEEF_CAFE_F00D, 73, 0};

    rst = 1'b1; en = 1'b1; key = '0; msg = '0; valid0 = 1'b0; valid1 = 1'b0; sel = 1'b0;
    #12;
    check("reset_ready", 64'(ready0), 64'(1));
    check("reset_outputs", 64'({ser0, lk0, lm0, busy0, done0}), 64'(0));
    check("reset_outputs_gap0", 64'({ser1, lk1, lm1, busy1, done1}), 64'(0));
    en = 1'b0;
    #1;
    check("reset_ready_follows_en", 64'(ready0), 64'(0));
    en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames on both gap configurations.
    for (int i = 0; i < 5; i++) begin
      handshake(vecs[i].sel, vecs[i].key, vecs[i].msg);
      capture(0, 0, 0, 8'h00);
      check_frame(vecs[i].exp_kb, vecs[i].exp_mb, vecs[i].exp_done, vecs[i].exp_done, vecs[i].exp_gap);
    end

    // End-to-end: the core XORs each message byte with the key.
    handshake(1'b0, 8'hFF, 64'h0000_0000_0000_00FF);
    capture(0, 0, 0, 8'h00);
    check("ciphertext", cap_mb ^ {8{cap_kb}}, 64'hFFFF_FFFF_FFFF_FF00);

    // Enable stall after the 3rd key bit: five frozen cycles, bit 4 resumes.
    handshake(1'b0, 8'hA5, 64'h0123_4567_89AB_CDEF);
    capture(4, 5, 0, 8'h00);
    check_frame(8'hA5, 64'h0123_4567_89AB_CDEF, 79, 79, 1);

    // Reset at message bit 20 (cycle 29) aborts immediately.
    handshake(1'b0, 8'hC3, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      if (c == 1) valid0 = 1'b0;
    end
    #1;
    check("pre_reset_msg_bit", 64'({ser0, lm0}), 64'(2'b11));
    rst = 1'b1;
    #1;
    check("midreset_outputs", 64'({ser0, lk0, lm0, busy0, done0}), 64'(0));
    check("midreset_ready", 64'(ready0), 64'(1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    handshake(1'b0, 8'h3C, 64'h0F0F_0F0F_0F0F_0F0F);
    capture(0, 0, 0, 8'h00);
    check_frame(8'h3C, 64'h0F0F_0F0F_0F0F_0F0F, 74, 74, 1);

    // New request during MSG is held off until the frame completes.
    handshake(1'b0, 8'hA5, 64'h0123_4567_89AB_CDEF);
    capture(0, 0, 20, 8'h3C);
    check_frame(8'hA5, 64'h0123_4567_89AB_CDEF, 74, 74, 1);
    capture(0, 0, 0, 8'h00);
    check_frame(8'h3C, 64'h1111_2222_3333_4444, 74, 74, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
